// File: rtl/zl_ts_energy_dispersal.sv
// DVB-S transport multiplex adaptation / energy dispersal: TX scrambles, RX descrambles, with sync-lock tracking.
// Define ZL_ED_STATS_EN to add the saturating grp_count / err_count statistics ports.
`timescale 1ns/1ps
module zl_ts_energy_dispersal #(
    parameter int          PACKET_LEN  = 188,
    parameter int          GROUP_LEN   = 8,
    parameter logic [7:0]  SYNC_BYTE   = 8'h47,
    parameter int          LOSS_THRESH = 3,
    parameter logic [14:0] LFSR_INIT   = 15'b100101010000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_rx,
    input  logic       data_in_req,
    output logic       data_in_ack,
    input  logic [7:0] data_in,
    output logic       data_out_req,
    input  logic       data_out_ack,
    output logic [7:0] data_out,
    output logic       data_out_sog,
    output logic       locked,
    output logic       sync_err
`ifdef ZL_ED_STATS_EN
    ,
    output logic [15:0] grp_count,
    output logic [15:0] err_count
`endif
);

    localparam int BW = $clog2(PACKET_LEN);
    localparam int PW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam int EW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {SEARCH, GSYNC, PSYNC, DATA} state_t;

    state_t      state, next_state;
    logic [BW-1:0] byte_cnt;
    logic [PW-1:0] pkt_cnt;
    logic [EW-1:0] err_cnt;
    logic [14:0] lfsr, lfsr_step;
    logic [7:0]  prbs;
    logic        mode_lat;
    logic [7:0]  gs_search, gs_lat;
    logic        drop, xfer, bad_gsync, bad_psync, loss, last_byte, last_pkt, group_done;

    // Eight shifts of 1+x^14+x^15 per byte; the feedback bit is the PRBS output, MSB first.
    always_comb begin
        lfsr_step = lfsr;
        prbs      = '0;
        for (int i = 0; i < 8; i++) begin
            prbs      = {prbs[6:0], lfsr_step[1] ^ lfsr_step[0]};
            lfsr_step = {lfsr_step[1] ^ lfsr_step[0], lfsr_step[14:1]};
        end
    end

    assign gs_search  = mode_rx  ? ~SYNC_BYTE : SYNC_BYTE;
    assign gs_lat     = mode_lat ? ~SYNC_BYTE : SYNC_BYTE;
    assign drop       = (state == SEARCH) && (data_in != gs_search);
    assign xfer       = data_in_req && data_out_ack && !drop;
    assign bad_gsync  = (state == GSYNC) && (data_in != gs_lat);
    assign bad_psync  = (state == PSYNC) && (data_in != SYNC_BYTE);
    assign loss       = bad_gsync && (err_cnt == EW'(LOSS_THRESH - 1));
    assign last_byte  = byte_cnt == BW'(PACKET_LEN - 1);
    assign last_pkt   = pkt_cnt == PW'(GROUP_LEN - 1);
    assign group_done = xfer && (state == DATA) && last_byte && last_pkt;

    always_ff @(posedge clk) begin
        if (rst) state <= SEARCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (xfer) begin
            case (state)
                SEARCH: next_state = DATA;
                GSYNC:  next_state = loss ? SEARCH : DATA;
                PSYNC:  next_state = DATA;
                DATA:   if (last_byte) next_state = last_pkt ? GSYNC : PSYNC;
                default: next_state = SEARCH;
            endcase
        end
    end

    // Dropped bytes in SEARCH are acked without waiting for the sink.
    always_comb begin
        data_out     = data_in;
        data_out_sog = 1'b0;
        data_out_req = data_in_req;
        data_in_ack  = data_in_req && data_out_ack;
        case (state)
            SEARCH: begin
                data_out     = ~data_in;
                data_out_sog = !drop;
                if (drop) begin
                    data_out_req = 1'b0;
                    data_in_ack  = data_in_req;
                end
            end
            GSYNC: begin
                data_out     = ~data_in;
                data_out_sog = 1'b1;
            end
            PSYNC:   data_out = data_in;
            DATA:    data_out = data_in ^ prbs;
            default: data_out = data_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
            lfsr     <= LFSR_INIT;
            mode_lat <= 1'b0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= xfer && (bad_gsync || bad_psync);
            if (xfer) begin
                case (state)
                    SEARCH: begin
                        mode_lat <= mode_rx;
                        byte_cnt <= BW'(1);
                        pkt_cnt  <= '0;
                        locked   <= 1'b1;
                    end
                    GSYNC: begin
                        byte_cnt <= BW'(1);
                        if (loss) begin
                            err_cnt <= '0;
                            locked  <= 1'b0;
                            lfsr    <= LFSR_INIT;
                        end else if (bad_gsync) begin
                            err_cnt <= err_cnt + EW'(1);
                        end else begin
                            err_cnt <= '0;
                        end
                    end
                    PSYNC: begin
                        byte_cnt <= BW'(1);
                        lfsr     <= lfsr_step;
                    end
                    DATA: begin
                        if (last_byte) begin
                            byte_cnt <= '0;
                            if (last_pkt) begin
                                pkt_cnt <= '0;
                                lfsr    <= LFSR_INIT;
                            end else begin
                                pkt_cnt <= pkt_cnt + PW'(1);
                                lfsr    <= lfsr_step;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BW'(1);
                            lfsr     <= lfsr_step;
                        end
                    end
                    default: byte_cnt <= '0;
                endcase
            end
        end
    end

`ifdef ZL_ED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_count <= '0;
            err_count <= '0;
        end else begin
            if (group_done && grp_count != 16'hFFFF)
                grp_count <= grp_count + 16'd1;
            if (xfer && (bad_gsync || bad_psync) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_zl_ts_energy_dispersal.sv
// Self-checking bench for zl_ts_energy_dispersal: SEARCH vector table, TX/RX groups, loss, backpressure, reset.
// Statistics checks are included when ZL_ED_STATS_EN is defined.
`timescale 1ns/1ps
module tb_zl_ts_energy_dispersal;

    localparam int          PL   = 188;
    localparam int          GN   = 8;
    localparam int          GL   = PL * GN;
    localparam logic [7:0]  SYNC = 8'h47;
    localparam logic [14:0] SEED = 15'b100101010000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_rx = 1'b0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic [7:0] data_in = 8'h00;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic [7:0] data_out;
    logic       data_out_sog;
    logic       locked;
    logic       sync_err;
`ifdef ZL_ED_STATS_EN
    logic [15:0] grp_count;
    logic [15:0] err_count;
`endif

    zl_ts_energy_dispersal #(
        .PACKET_LEN(PL), .GROUP_LEN(GN), .SYNC_BYTE(SYNC), .LOSS_THRESH(3), .LFSR_INIT(SEED)
    ) dut (
        .clk(clk), .rst(rst), .mode_rx(mode_rx),
        .data_in_req(data_in_req), .data_in_ack(data_in_ack), .data_in(data_in),
        .data_out_req(data_out_req), .data_out_ack(data_out_ack), .data_out(data_out),
        .data_out_sog(data_out_sog), .locked(locked), .sync_err(sync_err)
`ifdef ZL_ED_STATS_EN
        , .grp_count(grp_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int dropped = 0;
    logic       mode_base = 1'b0;
    bit         jitter = 1'b0;
    logic [7:0] prbs_seq [GL];
    logic [7:0] grp_in [GL];
    logic [7:0] tx_stream [2*GL];
    logic [7:0] out_q [$];
    logic       sog_q [$];
    logic [7:0] exp_b [$];
    logic       exp_s [$];

    typedef struct {
        logic       mode;
        logic [7:0] din;
        logic       oack;
        logic       e_oreq;
        logic       e_iack;
        logic       e_sog;
        logic       chk_out;
        logic [7:0] e_out;
    } vec_t;
    vec_t vecs [6];

    always @(negedge clk) if (sync_err === 1'b1) pulses++;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // DVB-S PRBS from the stage-numbered register description: stages 1..15, taps 14 and 15.
    task automatic build_prbs();
        bit s [1:15];
        bit fb;
        for (int k = 1; k <= 15; k++) s[k] = SEED[15-k];
        for (int n = 0; n < GL; n++) begin
            for (int b = 0; b < 8; b++) begin
                fb = s[14] ^ s[15];
                for (int k = 15; k >= 2; k--) s[k] = s[k-1];
                s[1] = fb;
                prbs_seq[n][7-b] = fb;
            end
        end
    endtask

    function automatic logic [7:0] exp_out(input int p, input logic [7:0] x);
        if (p == 0)      return ~x;
        if (p % PL == 0) return x;
        return x ^ prbs_seq[p-1];
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic compare_stream(input string name);
        int first = -1;
        total++;
        for (int i = 0; i < exp_b.size() && i < out_q.size(); i++)
            if (first < 0 && (out_q[i] !== exp_b[i] || sog_q[i] !== exp_s[i])) first = i;
        if (out_q.size() != exp_b.size()) begin
            bad++;
            $display("[TB] FAIL %s: got %0d bytes expected %0d", name, out_q.size(), exp_b.size());
        end else if (first >= 0) begin
            bad++;
            $display("[TB] FAIL %s: byte %0d got %h/sog%0b expected %h/sog%0b", name, first,
                     out_q[first], sog_q[first], exp_b[first], exp_s[first]);
        end
        out_q.delete(); sog_q.delete(); exp_b.delete(); exp_s.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_in_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        data_in_req  = 1'b0;
        data_out_ack = 1'b1;
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input bit bp);
        int  guard = 0;
        bit  done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            data_in      = b;
            data_in_req  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_out_ack = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            mode_rx      = jitter ? 1'($urandom_range(0, 1)) : mode_base;
            #1;
            if (data_out_req && data_out_ack) begin
                out_q.push_back(data_out);
                sog_q.push_back(data_out_sog);
            end
            if (data_in_req && data_in_ack) begin
                done = 1'b1;
                if (!data_out_req) dropped++;
            end
            guard++;
            if (!done && guard > 200) begin
                total++;
                bad++;
                $display("[TB] FAIL handshake timeout: got no ack expected ack within 200 cycles");
                done = 1'b1;
            end
        end
    endtask

    task automatic fill_group(input logic [7:0] gs, input int bad_pkt, input bit rnd);
        for (int p = 0; p < GL; p++) begin
            if (p == 0)           grp_in[p] = gs;
            else if (p % PL == 0) grp_in[p] = (p / PL == bad_pkt) ? 8'h00 : SYNC;
            else                  grp_in[p] = rnd ? 8'($urandom) : 8'h00;
        end
    endtask

    task automatic send_range(input int first, input int last, input bit bp);
        for (int p = first; p <= last; p++) begin
            if (bp && p > 0) jitter = 1'b1;
            apply_stimulus(grp_in[p], bp);
            exp_b.push_back(exp_out(p, grp_in[p]));
            exp_s.push_back(p == 0);
        end
        jitter = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        check_val(name, got, want);
    endtask

    initial begin
        int p0;
        vecs[0] = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h47, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB8};
        vecs[2] = '{1'b0, 8'hB8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'hB8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h47};
        vecs[4] = '{1'b1, 8'h47, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        build_prbs();

        // Reset state and SEARCH combinational behaviour
        do_reset();
        check_output("reset locked", 32'(locked), 0);
        check_output("reset sync_err", 32'(sync_err), 0);
        foreach (vecs[i]) begin
            @(negedge clk);
            mode_rx = vecs[i].mode; data_in = vecs[i].din;
            data_out_ack = vecs[i].oack; data_in_req = 1'b1;
            #1;
            check_output($sformatf("search[%0d] out_req", i), 32'(data_out_req), 32'(vecs[i].e_oreq));
            check_output($sformatf("search[%0d] in_ack", i), 32'(data_in_ack), 32'(vecs[i].e_iack));
            check_output($sformatf("search[%0d] sog", i), 32'(data_out_sog), 32'(vecs[i].e_sog));
            if (vecs[i].chk_out)
                check_output($sformatf("search[%0d] data", i), 32'(data_out), 32'(vecs[i].e_out));
        end
        idle_cycle();
        check_output("search keeps unlocked", 32'(locked), 0);

        // T1: TX, two groups of 0x47 + zeros
        mode_base = 1'b0;
        do_reset();
        fill_group(SYNC, -1, 1'b0);
        send_range(0, GL-1, 1'b0);
        send_range(0, GL-1, 1'b0);
        idle_cycle();
        check_output("tx first byte", 32'(out_q[0]), 32'h0B8);
        check_output("tx first sog", 32'(sog_q[0]), 1);
        check_output("tx first prbs byte", 32'(out_q[1]), 32'h03);
        check_output("tx pkt1 sync", 32'(out_q[PL]), 32'h47);
        check_output("tx pkt1 sog", 32'(sog_q[PL]), 0);
        check_output("tx group2 start", 32'(out_q[GL]), 32'h0B8);
        for (int i = 0; i < 2*GL; i++) tx_stream[i] = exp_out(i % GL, grp_in[i % GL]);
`ifdef ZL_ED_STATS_EN
        check_output("stats grp after tx", 32'(grp_count), 2);
`endif
        compare_stream("tx stream");

        // T2: RX of the TX stream recovers the original
        mode_base = 1'b1;
        do_reset();
        p0 = pulses;
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < GL; p++) grp_in[p] = tx_stream[g*GL + p];
            send_range(0, 0, 1'b0);
            if (g == 0) begin
                idle_cycle();
                check_output("rx locked after first byte", 32'(locked), 1);
            end
            send_range(1, GL-1, 1'b0);
        end
        idle_cycle();
        exp_b.delete(); exp_s.delete();
        for (int i = 0; i < 2*GL; i++) begin
            exp_b.push_back((i % PL == 0) ? ((i % GL == 0) ? 8'h47 : SYNC) : 8'h00);
            exp_s.push_back(i % GL == 0);
        end
        compare_stream("rx recovered");
        check_output("rx no sync_err", 32'(pulses - p0), 0);

        // T3: junk dropped in SEARCH, then lock on the first group sync
        mode_base = 1'b0;
        do_reset();
        dropped = 0;
        for (int i = 0; i < 5; i++) apply_stimulus(8'h12, 1'b0);
        idle_cycle();
        check_output("junk dropped", 32'(dropped), 5);
        check_output("junk no output", 32'(out_q.size()), 0);
        check_output("junk unlocked", 32'(locked), 0);
        fill_group(SYNC, -1, 1'b0);
        send_range(0, 0, 1'b0);
        idle_cycle();
        check_output("search lock", 32'(locked), 1);
        send_range(1, GL-1, 1'b0);
        idle_cycle();
        compare_stream("search group");

        // T4: packet-sync error, then group-sync errors until loss, then relock
        do_reset();
        p0 = pulses;
        fill_group(SYNC, 3, 1'b0);
        send_range(0, GL-1, 1'b0);
        idle_cycle();
        check_output("psync err pulse", 32'(pulses - p0), 1);
        check_output("psync err keeps lock", 32'(locked), 1);
        fill_group(8'h00, -1, 1'b0);
        send_range(0, GL-1, 1'b0);
        fill_group(SYNC, -1, 1'b0);
        send_range(0, GL-1, 1'b0);
        fill_group(8'h00, -1, 1'b0);
        send_range(0, GL-1, 1'b0);
        send_range(0, GL-1, 1'b0);
        idle_cycle();
        check_output("two bad gsyncs keep lock", 32'(locked), 1);
        send_range(0, 0, 1'b0);
        idle_cycle();
        check_output("loss unlocks", 32'(locked), 0);
        check_output("loss pulse count", 32'(pulses - p0), 5);
        fill_group(SYNC, -1, 1'b0);
        send_range(0, GL-1, 1'b0);
        idle_cycle();
        check_output("relock", 32'(locked), 1);
        compare_stream("loss stream");
`ifdef ZL_ED_STATS_EN
        check_output("stats grp after loss", 32'(grp_count), 6);
        check_output("stats err after loss", 32'(err_count), 5);
        do_reset();
        check_output("stats grp cleared", 32'(grp_count), 0);
        check_output("stats err cleared", 32'(err_count), 0);
`endif

        // T5: random backpressure, gaps and mode_rx jitter after lock
        do_reset();
        p0 = pulses;
        fill_group(SYNC, -1, 1'b0);
        send_range(0, GL-1, 1'b1);
        send_range(0, GL-1, 1'b1);
        idle_cycle();
        exp_b.delete(); exp_s.delete();
        for (int i = 0; i < 2*GL; i++) begin
            exp_b.push_back(tx_stream[i]);
            exp_s.push_back(i % GL == 0);
        end
        compare_stream("backpressure stream");
        check_output("backpressure no sync_err", 32'(pulses - p0), 0);

        // Reset mid-packet, then a random-data group
        mode_base = 1'b0;
        do_reset();
        fill_group(SYNC, -1, 1'b1);
        send_range(0, 99, 1'b0);
        do_reset();
        check_output("mid-packet reset unlocks", 32'(locked), 0);
        fill_group(SYNC, -1, 1'b1);
        send_range(0, GL-1, 1'b0);
        idle_cycle();
        compare_stream("random group after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
